// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: 32-bit PC plus a 2-entry {pc, instr} fetch buffer
// feeding decode with a valid/ready handshake. Redirects flush the buffer and
// reload the PC.
// Optional build macro IFU_PERF_CNT_EN adds o_fetch_count, a wrapping count of
// completed decode handshakes.
`timescale 1ns/1ps
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [7:0]  o_imem_addr,
  input  logic [31:0] i_imem_data,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] o_fetch_count
`endif
);

  // Fetch addresses are word aligned; the low two bits of any PC source are dropped.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t        r_state;
  occ_t        w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  // Entry 0 is always the head; entry 1 is only meaningful when FULL.
  logic [31:0] r_e0_pc;
  logic [31:0] r_e0_instr;
  logic [31:0] r_e1_pc;
  logic [31:0] r_e1_instr;
  logic [31:0] w_e0_pc_next;
  logic [31:0] w_e0_instr_next;
  logic [31:0] w_e1_pc_next;
  logic [31:0] w_e1_instr_next;
  logic        w_valid;
  logic        w_pop;
  logic        w_push;
  logic        w_unused_redirect_lsbs;

  assign w_valid = (r_state != EMPTY);
  assign w_pop   = w_valid & i_ready;
  // A fetch needs a free slot, or one being freed by a pop this cycle.
  assign w_push  = ~i_redirect & ((r_state != FULL) | w_pop);

  assign w_unused_redirect_lsbs = ^i_redirect_pc[1:0];

  // Next buffer occupancy, buffer contents and PC for the current handshake/redirect.
  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_e0_pc_next    = r_e0_pc;
    w_e0_instr_next = r_e0_instr;
    w_e1_pc_next    = r_e1_pc;
    w_e1_instr_next = r_e1_instr;
    if (i_redirect) begin
      // Redirect wins over everything: drop both entries (and any pop) and restart.
      w_state_next = EMPTY;
      w_pc_next    = {i_redirect_pc[31:2], 2'b00};
    end else begin
      if (w_push) begin
        w_pc_next = r_pc + 32'd4;
      end
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            w_e0_pc_next    = r_pc;
            w_e0_instr_next = i_imem_data;
            w_state_next    = ONE;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            w_e0_pc_next    = r_pc;
            w_e0_instr_next = i_imem_data;
          end else if (w_push) begin
            w_e1_pc_next    = r_pc;
            w_e1_instr_next = i_imem_data;
            w_state_next    = FULL;
          end else if (w_pop) begin
            w_state_next = EMPTY;
          end
        end
        FULL: begin
          if (w_pop) begin
            // Shift the second entry to the head so order is preserved.
            w_e0_pc_next    = r_e1_pc;
            w_e0_instr_next = r_e1_instr;
            if (w_push) begin
              w_e1_pc_next    = r_pc;
              w_e1_instr_next = i_imem_data;
            end else begin
              w_state_next = ONE;
            end
          end
        end
        default: begin
          w_state_next = EMPTY;
        end
      endcase
    end
  end

  // State registers; reset clears the buffer and reloads the PC immediately.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= EMPTY;
      r_pc       <= RESET_PC_ALIGNED;
      r_e0_pc    <= '0;
      r_e0_instr <= '0;
      r_e1_pc    <= '0;
      r_e1_instr <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_e0_pc    <= w_e0_pc_next;
      r_e0_instr <= w_e0_instr_next;
      r_e1_pc    <= w_e1_pc_next;
      r_e1_instr <= w_e1_instr_next;
    end
  end

  // Head entry is presented only while the buffer holds something.
  always_comb begin
    o_valid     = w_valid;
    o_imem_addr = r_pc[9:2];
    o_instr     = w_valid ? r_e0_instr : 32'd0;
    o_pc        = w_valid ? r_e0_pc : 32'd0;
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] r_fetch_count;

  // Count every accepted head entry, including ones discarded by a redirect.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_fetch_count <= '0;
    end else if (w_pop) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign o_fetch_count = r_fetch_count;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: cycle-exact vector table, reset/random sequences,
// and an in-order stream scoreboard for instruction_fetch_unit.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [7:0]  imem_addr2;
  logic [31:0] imem_data2;
  logic        valid2;
  logic [31:0] instr2;
  logic [31:0] pc2;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] fetch_count2;
`endif

  logic [31:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;
  int hs_count = 0;
  logic [31:0] sb_q [$];

  typedef struct {
    logic        ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [7:0]  exp_addr;
  } vec_t;

  localparam int NV = 18;
  vec_t vec [NV];

  always #5 clk = ~clk;

  assign imem_data  = mem[imem_addr];
  assign imem_data2 = mem[imem_addr2];

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .o_imem_addr   (imem_addr),
    .i_imem_data   (imem_data),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_valid       (valid),
    .i_ready       (ready),
    .o_instr       (instr),
    .o_pc          (pc)
`ifdef IFU_PERF_CNT_EN
    ,
    .o_fetch_count (fetch_count)
`endif
  );

  instruction_fetch_unit #(.RESET_PC(32'h0000_03FC)) dut2 (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .o_imem_addr   (imem_addr2),
    .i_imem_data   (imem_data2),
    .i_redirect    (1'b0),
    .i_redirect_pc (32'h0000_0000),
    .o_valid       (valid2),
    .i_ready       (1'b1),
    .o_instr       (instr2),
    .o_pc          (pc2)
`ifdef IFU_PERF_CNT_EN
    ,
    .o_fetch_count (fetch_count2)
`endif
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected in-order delivery stream starting at an aligned address.
  task automatic sb_restart(input logic [31:0] start);
    sb_q.delete();
    for (int k = 0; k < 512; k++) sb_q.push_back(start + 32'(4 * k));
  endtask

  // Handshake monitor: each accepted head must be the next address of the stream.
  always @(negedge clk) begin
    logic [31:0] exp_pc;
    if (rst_n && valid && ready) begin
      hs_count++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: handshake at o_pc %h, nothing expected", pc);
      end else begin
        exp_pc = sb_q.pop_front();
        $display("hs %0d: o_pc=%h o_instr=%h expected pc=%h", hs_count, pc, instr, exp_pc);
        check32("sb_pc", pc, exp_pc);
        check32("sb_instr", instr, {24'h0, exp_pc[9:2]});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got %0t, limit 1000000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp2_pc [3];
    logic [7:0]  exp2_addr [3];
    logic [31:0] tgt;
    logic        prev_valid;
    logic [31:0] prev_pc;
    int          hs_start;

    for (int k = 0; k < 256; k++) mem[k] = 32'(k);

    // ready, redirect, redirect_pc, exp_valid, exp_pc, exp_addr (after the edge)
    vec[0]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 8'd1};
    vec[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 8'd2};
    vec[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 8'd2};
    vec[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 8'd2};
    vec[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 8'd2};
    vec[5]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 8'd3};
    vec[6]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0008, 8'd4};
    vec[7]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_000C, 8'd5};
    vec[8]  = '{1'b1, 1'b1, 32'h0000_0103, 1'b0, 32'h0000_0000, 8'd64};
    vec[9]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0100, 8'd65};
    vec[10] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0100, 8'd66};
    vec[11] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0104, 8'd67};
    vec[12] = '{1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0000_0000, 8'd255};
    vec[13] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 8'd0};
    vec[14] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 8'd1};
    vec[15] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 8'd2};
    vec[16] = '{1'b1, 1'b1, 32'h0000_0041, 1'b0, 32'h0000_0000, 8'd16};
    vec[17] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0040, 8'd17};

    exp2_pc[0] = 32'h0000_03FC; exp2_addr[0] = 8'd0;
    exp2_pc[1] = 32'h0000_0400; exp2_addr[1] = 8'd1;
    exp2_pc[2] = 32'h0000_0404; exp2_addr[2] = 8'd2;

    rst_n = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    check32("rst_valid", {31'd0, valid}, 32'd0);
    check32("rst_pc", pc, 32'd0);
    check32("rst_instr", instr, 32'd0);
    check32("rst_addr", {24'd0, imem_addr}, 32'd0);
    check32("rst_valid2", {31'd0, valid2}, 32'd0);
    check32("rst_addr2", {24'd0, imem_addr2}, 32'd255);
`ifdef IFU_PERF_CNT_EN
    check32("rst_count", fetch_count, 32'd0);
`endif

    // Table phase: release reset, then one vector per clock edge.
    sb_restart(32'h0);
    hs_count = 0;
    rst_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      ready       = vec[i].ready;
      redirect    = vec[i].redirect;
      redirect_pc = vec[i].redirect_pc;
      @(posedge clk);
      #1;
      if (vec[i].redirect) sb_restart({vec[i].redirect_pc[31:2], 2'b00});
      $display("vec %0d: ready=%b redirect=%b -> valid=%b o_pc=%h o_instr=%h addr=%0d",
               i, vec[i].ready, vec[i].redirect, valid, pc, instr, imem_addr);
      check32("vec_valid", {31'd0, valid}, {31'd0, vec[i].exp_valid});
      check32("vec_pc", pc, vec[i].exp_pc);
      check32("vec_instr", instr, vec[i].exp_valid ? {24'h0, vec[i].exp_pc[9:2]} : 32'd0);
      check32("vec_addr", {24'd0, imem_addr}, {24'd0, vec[i].exp_addr});
`ifdef IFU_PERF_CNT_EN
      check32("vec_count", fetch_count, 32'(hs_count));
`endif
      if (i < 3) begin
        check32("wrap_valid2", {31'd0, valid2}, 32'd1);
        check32("wrap_pc2", pc2, exp2_pc[i]);
        check32("wrap_instr2", instr2, {24'h0, exp2_pc[i][9:2]});
        check32("wrap_addr2", {24'd0, imem_addr2}, {24'd0, exp2_addr[i]});
      end
    end
    redirect = 1'b0;

    // Fill the buffer, then pulse reset mid-cycle: outputs must drop at once.
    ready = 1'b0;
    @(posedge clk);
    #1;
    check32("full_pc", pc, 32'h0000_0040);
    check32("full_addr", {24'd0, imem_addr}, 32'd18);
    #3;
    rst_n = 1'b0;
    #1;
    $display("reset pulse: valid=%b o_pc=%h o_instr=%h addr=%0d", valid, pc, instr, imem_addr);
    check32("async_valid", {31'd0, valid}, 32'd0);
    check32("async_pc", pc, 32'd0);
    check32("async_instr", instr, 32'd0);
    check32("async_addr", {24'd0, imem_addr}, 32'd0);
`ifdef IFU_PERF_CNT_EN
    check32("async_count", fetch_count, 32'd0);
`endif
    hs_count = 0;
    sb_restart(32'h0);
    ready = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk);
      #1;
      $display("restart %0d: valid=%b o_pc=%h o_instr=%h addr=%0d", j, valid, pc, instr, imem_addr);
      check32("restart_valid", {31'd0, valid}, 32'd1);
      check32("restart_pc", pc, 32'(4 * j));
      check32("restart_instr", instr, 32'(j));
      check32("restart_addr", {24'd0, imem_addr}, 32'(j + 1));
`ifdef IFU_PERF_CNT_EN
      check32("restart_count", fetch_count, 32'(hs_count));
`endif
    end

    // Random phase: random ready and occasional redirects, stream checked by the scoreboard.
    hs_start = hs_count;
    for (int c = 0; c < 300; c++) begin
      prev_valid  = valid;
      prev_pc     = pc;
      ready       = 1'($urandom_range(0, 1));
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      tgt         = {redirect_pc[31:2], 2'b00};
      @(posedge clk);
      #1;
      if (redirect) begin
        sb_restart(tgt);
        check32("rand_redir_valid", {31'd0, valid}, 32'd0);
        check32("rand_redir_addr", {24'd0, imem_addr}, {24'd0, tgt[9:2]});
      end else if (prev_valid && !ready) begin
        check32("rand_hold_valid", {31'd0, valid}, 32'd1);
        check32("rand_hold_pc", pc, prev_pc);
      end
    end
    redirect = 1'b0;
`ifdef IFU_PERF_CNT_EN
    check32("rand_count", fetch_count, 32'(hs_count));
`endif
    n_checks++;
    if (hs_count - hs_start < 50) begin
      n_fail++;
      $display("FAIL rand_progress: got %0d handshakes, required at least 50", hs_count - hs_start);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
